// File: rtl/pll_supervisor_pkg.sv
// Shared types and elaboration-time helpers for the PLL supervisor.
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // Widest packed divide vector supported: 8 channels of up to 32 bits.
  localparam int DIV_VEC_W = 256;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] ch_div_slice(input logic [DIV_VEC_W-1:0] vec,
                                               input int k, input int w);
    logic [DIV_VEC_W-1:0] shifted;
    logic [31:0]          mask;
    shifted = vec >> (k * w);
    mask    = (32'd1 << w) - 32'd1;
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// One channel's clock-enable divider; idles at zero while the channel is held in reset.
module ce_divider
  import pll_supervisor_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_reg <= '0;
    end else if (!run) begin
      cnt_reg <= '0;
    end else if (cnt_reg == '0) begin
      // A divide of 0 behaves as divide-by-1: the counter never leaves zero.
      cnt_reg <= (div == '0) ? '0 : div - DIV_W'(1);
    end else begin
      cnt_reg <= cnt_reg - DIV_W'(1);
    end
  end

  // Zero count means "enable now", so the first released cycle already pulses.
  assign ce = run & (cnt_reg == '0);

endmodule

// File: rtl/pll_supervisor.sv
// rPLL supervisor: drives PLL RESET, qualifies LOCK, releases channel resets in order
// and generates per-channel clock enables.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int                      NUM_CH        = 3,
  parameter int                      DIV_W         = 8,
  parameter logic [NUM_CH*DIV_W-1:0] CH_DIV        = {8'd4, 8'd2, 8'd1},
  parameter int                      RST_CYCLES    = 16,
  parameter int                      LOCK_TIMEOUT  = 4000,
  parameter int                      STABLE_CYCLES = 256,
  parameter int                      RELEASE_GAP   = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              pll_lock_i,
  output logic              pll_reset_o,
  output logic              locked_o,
  output logic [NUM_CH-1:0] ch_reset_n_o,
  output logic [NUM_CH-1:0] ch_ce_o,
  output logic [7:0]        relock_cnt_o,
  output logic [2:0]        state_o
);

  localparam int TMR_W = clog2(max_int(max_int(RST_CYCLES, LOCK_TIMEOUT),
                                       max_int(STABLE_CYCLES, NUM_CH * RELEASE_GAP))) + 1;

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RELEASE_LAST = TMR_W'((NUM_CH - 1) * RELEASE_GAP);

  logic [1:0]        sync_reg;
  logic              lock_s;
  state_t            state_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [TMR_W-1:0]  timer_inc;
  logic              pll_reset_reg;
  logic              locked_reg;
  logic [NUM_CH-1:0] ch_rst_n_reg;
  logic [NUM_CH-1:0] step_hit;
  logic [7:0]        relock_reg;
  logic [7:0]        relock_inc;

  // LOCK comes from the PLL's own domain; two flops before anything looks at it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pll_lock_i};
    end
  end

  assign lock_s     = sync_reg[1];
  assign timer_inc  = timer_reg + TMR_W'(1);
  assign relock_inc = (relock_reg == 8'hFF) ? relock_reg : relock_reg + 8'd1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= ST_PLL_RST;
      timer_reg     <= '0;
      pll_reset_reg <= 1'b1;
      locked_reg    <= 1'b0;
      ch_rst_n_reg  <= '0;
      relock_reg    <= '0;
    end else begin
      case (state_reg)
        ST_PLL_RST: begin
          if (timer_reg == RST_LAST) begin
            state_reg     <= ST_WAIT_LOCK;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b0;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (lock_s) begin
            state_reg <= ST_STABLE;
            timer_reg <= '0;
          end else if (timer_reg == TIMEOUT_LAST) begin
            state_reg     <= ST_PLL_RST;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b1;
            relock_reg    <= relock_inc;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_reg <= ST_WAIT_LOCK;
            timer_reg <= '0;
          end else if (timer_reg == STABLE_LAST) begin
            state_reg    <= ST_RELEASE;
            timer_reg    <= '0;
            ch_rst_n_reg <= NUM_CH'(1);
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            state_reg     <= ST_PLL_RST;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b1;
            locked_reg    <= 1'b0;
            ch_rst_n_reg  <= '0;
            relock_reg    <= relock_inc;
          end else if (state_reg == ST_RELEASE) begin
            if (timer_reg == RELEASE_LAST) begin
              state_reg  <= ST_RUN;
              timer_reg  <= '0;
              locked_reg <= 1'b1;
            end else begin
              timer_reg    <= timer_inc;
              ch_rst_n_reg <= ch_rst_n_reg | step_hit;
            end
          end
        end
        default: begin
          state_reg     <= ST_PLL_RST;
          timer_reg     <= '0;
          pll_reset_reg <= 1'b1;
          locked_reg    <= 1'b0;
          ch_rst_n_reg  <= '0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [DIV_W-1:0] DIV_K =
        DIV_W'(ch_div_slice(DIV_VEC_W'(CH_DIV), gi, DIV_W));

      // Channel gi leaves reset in the cycle where the release timer equals gi*RELEASE_GAP.
      assign step_hit[gi] = (timer_inc == TMR_W'(gi * RELEASE_GAP));

      ce_divider #(
        .DIV_W(DIV_W)
      ) u_ce (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .run      (ch_rst_n_reg[gi]),
        .div      (DIV_K),
        .ce       (ch_ce_o[gi])
      );
    end
  endgenerate

  assign pll_reset_o  = pll_reset_reg;
  assign locked_o     = locked_reg;
  assign ch_reset_n_o = ch_rst_n_reg;
  assign relock_cnt_o = relock_reg;
  assign state_o      = state_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: bring-up, timeout, debounce, lock loss, async reset, saturation.
module tb_pll_supervisor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       locked;
  logic [2:0] ch_reset_n;
  logic [2:0] ch_ce;
  logic [7:0] relock;
  logic [2:0] state;

  // Short-timing instance that never sees lock, used to drive the retry counter into saturation.
  logic       f_reset_n;
  logic       f_lock;
  logic       f_pll_reset;
  logic       f_locked;
  logic [0:0] f_ch_reset_n;
  logic [0:0] f_ch_ce;
  logic [7:0] f_relock;
  logic [2:0] f_state;

  int total = 0;
  int bad   = 0;

  pll_supervisor u_dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .pll_lock_i  (pll_lock),
    .pll_reset_o (pll_reset),
    .locked_o    (locked),
    .ch_reset_n_o(ch_reset_n),
    .ch_ce_o     (ch_ce),
    .relock_cnt_o(relock),
    .state_o     (state)
  );

  pll_supervisor #(
    .NUM_CH       (1),
    .DIV_W        (8),
    .CH_DIV       (8'd0),
    .RST_CYCLES   (2),
    .LOCK_TIMEOUT (4),
    .STABLE_CYCLES(4),
    .RELEASE_GAP  (1)
  ) u_fast (
    .clk_i       (clk),
    .reset_n_i   (f_reset_n),
    .pll_lock_i  (f_lock),
    .pll_reset_o (f_pll_reset),
    .locked_o    (f_locked),
    .ch_reset_n_o(f_ch_reset_n),
    .ch_ce_o     (f_ch_ce),
    .relock_cnt_o(f_relock),
    .state_o     (f_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [2:0] seen;
    logic [2:0] ce_exp [8];
    ce_exp = '{3'b111, 3'b001, 3'b011, 3'b001, 3'b111, 3'b001, 3'b011, 3'b001};

    reset_n   = 1'b0;
    f_reset_n = 1'b0;
    pll_lock  = 1'b0;
    f_lock    = 1'b0;
    step();
    step();
    check("rst_pll_reset", 32'(pll_reset), 1);
    check("rst_locked", 32'(locked), 0);
    check("rst_ch_reset_n", 32'(ch_reset_n), 0);
    check("rst_ce", 32'(ch_ce), 0);
    check("rst_relock", 32'(relock), 0);
    check("rst_state", 32'(state), 0);

    // Nominal bring-up
    reset_n   = 1'b1;
    f_reset_n = 1'b1;
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin step(); n++; end
    check("pll_rst_pulse", 32'(n), 16);
    check("state_wait_lock", 32'(state), 1);
    repeat (50) step();
    pll_lock = 1'b1;
    repeat (3) step();
    check("state_stable", 32'(state), 2);
    n = 0;
    while (ch_reset_n[0] !== 1'b1 && n < 400) begin step(); n++; end
    check("stable_to_rel0", 32'(n), 256);
    check("rel0_only", 32'(ch_reset_n), 1);
    check("ce_at_rel0", 32'(ch_ce), 1);
    n = 0;
    while (ch_reset_n[1] !== 1'b1 && n < 50) begin step(); n++; end
    check("gap_ch1", 32'(n), 8);
    check("ce_at_rel1", 32'(ch_ce), 3);
    n = 0;
    while (ch_reset_n[2] !== 1'b1 && n < 50) begin step(); n++; end
    check("gap_ch2", 32'(n), 8);
    check("ce_pat0", 32'(ch_ce), 32'(ce_exp[0]));
    check("locked_in_release", 32'(locked), 0);
    step();
    check("locked_run", 32'(locked), 1);
    check("state_run", 32'(state), 4);
    check("ce_pat1", 32'(ch_ce), 32'(ce_exp[1]));
    for (int i = 2; i < 8; i++) begin
      step();
      check($sformatf("ce_pat%0d", i), 32'(ch_ce), 32'(ce_exp[i]));
    end

    // Lock loss in RUN
    pll_lock = 1'b0;
    n = 0;
    while (ch_reset_n !== 3'b000 && n < 10) begin step(); n++; end
    check("runloss_latency", 32'(n), 3);
    check("runloss_ce", 32'(ch_ce), 0);
    check("runloss_locked", 32'(locked), 0);
    check("runloss_state", 32'(state), 0);
    check("runloss_pll_reset", 32'(pll_reset), 1);
    check("runloss_relock", 32'(relock), 1);
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin step(); n++; end
    check("runloss_pulse", 32'(n), 16);

    // Lock glitch during STABLE
    repeat (10) step();
    pll_lock = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 20) begin step(); n++; end
    check("glitch_enter_stable", 32'(n), 3);
    repeat (100) step();
    pll_lock = 1'b0;
    repeat (3) step();
    check("glitch_state", 32'(state), 1);
    check("glitch_relock", 32'(relock), 1);
    pll_lock = 1'b1;
    n = 0;
    while (ch_reset_n[0] !== 1'b1 && n < 400) begin step(); n++; end
    check("glitch_requal", 32'(n), 259);

    // Lock loss mid-RELEASE, after channel 0 only
    repeat (2) step();
    pll_lock = 1'b0;
    repeat (3) step();
    check("relloss_state", 32'(state), 0);
    check("relloss_ch_reset_n", 32'(ch_reset_n), 0);
    check("relloss_relock", 32'(relock), 2);
    seen = 3'b000;
    repeat (12) begin step(); seen |= ch_reset_n; end
    check("relloss_ch_never", 32'(seen), 0);

    // Clean re-release, then async reset while in RUN
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 600) begin step(); n++; end
    check("rerelease_time", 32'(n), 278);
    check("rerelease_ch", 32'(ch_reset_n), 7);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_pll_reset", 32'(pll_reset), 1);
    check("areset_locked", 32'(locked), 0);
    check("areset_ch_reset_n", 32'(ch_reset_n), 0);
    check("areset_ce", 32'(ch_ce), 0);
    check("areset_relock", 32'(relock), 0);
    check("areset_state", 32'(state), 0);
    pll_lock = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Lock timeout retries
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin step(); n++; end
    check("to_first_pulse", 32'(n), 16);
    for (int i = 1; i <= 3; i++) begin
      n = 0;
      while (pll_reset !== 1'b1 && n < 5000) begin step(); n++; end
      check($sformatf("to_wait%0d", i), 32'(n), 4000);
      check($sformatf("to_relock%0d", i), 32'(relock), 32'(i));
      n = 0;
      while (pll_reset === 1'b1 && n < 100) begin step(); n++; end
      check($sformatf("to_pulse%0d", i), 32'(n), 16);
    end

    // Saturation on the short-timing instance (thousands of timeouts by now)
    check("sat_relock", 32'(f_relock), 255);
    check("sat_locked", 32'(f_locked), 0);
    check("sat_ch_reset_n", 32'(f_ch_reset_n), 0);
    check("sat_ce", 32'(f_ch_ce), 0);
    check("sat_state_low", 32'(f_state <= 3'd1), 1);
    check("sat_pll_reset_known", 32'(f_pll_reset === 1'bx), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
